// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: binary-search client of a registered comparator.
// Drives the comparator B input with successive guesses and narrows the
// [lo, hi] window from the GT/LT/EQ flags until a hit, an empty window,
// an edge of the value range, or a non-one-hot flag set ends the search.
// Optional: define SAR_STEP_COUNT_EN to add the steps[7:0] output, which
// counts EVAL cycles of the current/last search.
module sar_search_ctrl #(
    parameter int N       = 4,
    parameter int CMP_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         cmp_gt,
    input  logic         cmp_lt,
    input  logic         cmp_eq,
    output logic [N-1:0] cmp_b,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         err,
    output logic [N-1:0] result
`ifdef SAR_STEP_COUNT_EN
    ,
    output logic [7:0]   steps
`endif
);

    localparam int CW = (CMP_LAT < 2) ? 1 : $clog2(CMP_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    state_t        state;
    logic [N:0]    lo;
    logic [N:0]    hi;
    logic [CW-1:0] wcnt;

    logic [N-1:0]  mid;
    logic [N:0]    lo_up;
    logic [N:0]    hi_dn;
    logic          onehot;
    logic          ev_stop;

    // Midpoint of the window and the candidate bounds for the next step;
    // ev_stop flags every way the current EVAL can end the search.
    always_comb begin
        mid     = N'((lo + hi) >> 1);
        lo_up   = (N+1)'(mid) + (N+1)'(1);
        hi_dn   = (N+1)'(mid) - (N+1)'(1);
        onehot  = ( cmp_gt & ~cmp_lt & ~cmp_eq) |
                  (~cmp_gt &  cmp_lt & ~cmp_eq) |
                  (~cmp_gt & ~cmp_lt &  cmp_eq);
        ev_stop = 1'b0;
        if (!onehot || cmp_eq) begin
            ev_stop = 1'b1;
        end else if (cmp_gt) begin
            ev_stop = (mid == '1) || (lo_up > hi);
        end else begin
            ev_stop = (mid == '0) || (lo > hi_dn);
        end
    end

    // Search sequencer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            lo     <= '0;
            hi     <= (N+1)'((1 << N) - 1);
            wcnt   <= '0;
            cmp_b  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
`ifdef SAR_STEP_COUNT_EN
            steps  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lo    <= '0;
                        hi    <= (N+1)'((1 << N) - 1);
                        found <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
`ifdef SAR_STEP_COUNT_EN
                        steps <= '0;
`endif
                        state <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    cmp_b <= mid;
                    wcnt  <= CW'(CMP_LAT);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wcnt <= CW'(1)) begin
                        state <= S_EVAL;
                    end else begin
                        wcnt <= wcnt - CW'(1);
                    end
                end
                S_EVAL: begin
`ifdef SAR_STEP_COUNT_EN
                    steps <= steps + 8'd1;
`endif
                    if (ev_stop) begin
                        found  <= onehot & cmp_eq;
                        err    <= ~onehot;
                        result <= mid;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        if (cmp_gt) begin
                            lo <= lo_up;
                        end else begin
                            hi <= hi_dn;
                        end
                        state <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl (N=4, CMP_LAT=1) with a registered
// behavioural comparator. The comparator works on a doubled, offset target
// (a2 = 2*A + 2) so half-integer and out-of-range targets can exercise the
// not-found exits.
module tb_sar_search_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cmp_gt, cmp_lt, cmp_eq;
    logic [3:0] cmp_b;
    logic       busy, done, found, err;
    logic [3:0] result;
`ifdef SAR_STEP_COUNT_EN
    logic [7:0] steps;
`endif

    logic [6:0] a2;
    logic       force_bad;
    logic [6:0] bb;
    logic       c_gt, c_lt, c_eq;

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    sar_search_ctrl #(.N(4), .CMP_LAT(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .cmp_b  (cmp_b),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .err    (err),
        .result (result)
`ifdef SAR_STEP_COUNT_EN
        ,
        .steps  (steps)
`endif
    );

    // Registered comparator: flags follow cmp_b one edge later.
    assign bb = {2'b00, cmp_b, 1'b0} + 7'd2;
    always_ff @(posedge clk) begin
        c_gt <= (a2 > bb);
        c_lt <= (a2 < bb);
        c_eq <= (a2 == bb);
    end
    assign cmp_gt = c_gt | force_bad;
    assign cmp_lt = c_lt | force_bad;
    assign cmp_eq = c_eq & ~force_bad;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " cmp_b"}, int'(cmp_b), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " found"}, int'(found), 0);
        chk({tag, " err"}, int'(err), 0);
        chk({tag, " result"}, int'(result), 0);
`ifdef SAR_STEP_COUNT_EN
        chk({tag, " steps"}, int'(steps), 0);
`endif
    endtask

    typedef struct {
        logic [6:0]  a2;
        logic        bad;
        logic [19:0] g;
        int          ng;
        int          cyc;
        int          fnd;
        int          er;
        int          res;
        int          stp;
        int          mode;   // 0 plain, 1 extra start while busy, 2 start during DONE
    } vec_t;

    // One search: start in IDLE, check guesses at their expected cycles,
    // done timing, single done pulse, and held outputs afterwards.
    task automatic run_search(input vec_t v, input int id);
        int          done_c;
        int          dcount;
        int          gi;
        logic [19:0] gw;
        string       t;
        t      = $sformatf("v%0d", id);
        gw     = v.g;
        done_c = -1;
        dcount = 0;
        gi     = 0;
        a2        = v.a2;
        force_bad = v.bad;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({t, " busy after start"}, int'(busy), 1);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (v.mode == 1 && c == 4) start = 1'b1;
            if (((c - 1) % 3) == 0 && gi < v.ng) begin
                chk($sformatf("%s guess%0d", t, gi), int'(cmp_b), int'(gw[4*gi +: 4]));
                gi++;
            end
            if (done) begin
                dcount++;
                if (done_c < 0) begin
                    done_c = c;
                    if (v.mode == 2) start = 1'b1;
                end
            end
            if (done_c > 0 && c >= done_c + 3) break;
        end
        start = 1'b0;
        force_bad = 1'b0;
        chk({t, " done cycle"}, done_c, v.cyc);
        chk({t, " done pulses"}, dcount, 1);
        chk({t, " busy after"}, int'(busy), 0);
        chk({t, " found"}, int'(found), v.fnd);
        chk({t, " err"}, int'(err), v.er);
        chk({t, " result"}, int'(result), v.res);
`ifdef SAR_STEP_COUNT_EN
        chk({t, " steps"}, int'(steps), v.stp);
`endif
    endtask

    vec_t vt[10];
    vec_t vr;

    initial begin
        // a2 = 2*A + 2; 21 is A=9.5, 34 is A=16, 1 is A=-0.5
        vt[0] = '{7'd22, 1'b0, {4'd0,  4'd10, 4'd9,  4'd11, 4'd7}, 4, 12, 1, 0, 10, 4, 0};
        vt[1] = '{7'd32, 1'b0, {4'd15, 4'd14, 4'd13, 4'd11, 4'd7}, 5, 15, 1, 0, 15, 5, 1};
        vt[2] = '{7'd2,  1'b0, {4'd0,  4'd0,  4'd1,  4'd3,  4'd7}, 4, 12, 1, 0, 0,  4, 0};
        vt[3] = '{7'd16, 1'b0, {4'd0,  4'd0,  4'd0,  4'd0,  4'd7}, 1, 3,  1, 0, 7,  1, 2};
        vt[4] = '{7'd18, 1'b0, {4'd0,  4'd8,  4'd9,  4'd11, 4'd7}, 4, 12, 1, 0, 8,  4, 0};
        vt[5] = '{7'd12, 1'b0, {4'd0,  4'd0,  4'd5,  4'd3,  4'd7}, 3, 9,  1, 0, 5,  3, 0};
        vt[6] = '{7'd21, 1'b0, {4'd0,  4'd10, 4'd9,  4'd11, 4'd7}, 4, 12, 0, 0, 10, 4, 0};
        vt[7] = '{7'd34, 1'b0, {4'd15, 4'd14, 4'd13, 4'd11, 4'd7}, 5, 15, 0, 0, 15, 5, 2};
        vt[8] = '{7'd1,  1'b0, {4'd0,  4'd0,  4'd1,  4'd3,  4'd7}, 4, 12, 0, 0, 0,  4, 0};
        vt[9] = '{7'd22, 1'b1, {4'd0,  4'd0,  4'd0,  4'd0,  4'd7}, 1, 3,  0, 1, 7,  1, 0};

        reset     = 1'b1;
        start     = 1'b0;
        a2        = 7'd0;
        force_bad = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_search(vt[i], i);
        end

        // Reset during the WAIT of step 2 clears everything immediately.
        a2 = 7'd22;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        vr = '{7'd12, 1'b0, {4'd0, 4'd0, 4'd5, 4'd3, 4'd7}, 3, 9, 1, 0, 5, 3, 0};
        run_search(vr, 10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
